arcade_input_mapper: RTL

Parametrised input front end for arcade cores. Merges PS/2 keyboard events and up to four HPS joystick words into per-player button vectors, start lines and frame-timed coin pulses. It sits between `hps_io` and the game core, replacing ad-hoc per-core keyboard decoding. It adds shared/separate joystick routing and a coin pulse shaper that the per-core logic lacks.

---
 rtl/arcade_input_pkg.sv | 37 +++
 rtl/coin_pulser.sv | 85 ++++++++
 rtl/arcade_input_mapper.sv | 129 ++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front end: button bit positions, PS/2 scancodes and coin FSM states.
// Pure declarations; no logic, no latency.
package arcade_input_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_D     = 7;
    localparam int BTN_START = 8;
    localparam int BTN_COIN  = 9;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_GAP   = 2'd2
    } coin_state_t;

endpackage

// File: rtl/coin_pulser.sv
// Shapes a coin request into a COIN_FRAMES-tick pulse followed by a COIN_FRAMES-tick gap; one queued retrigger.
// Request edge registered at n -> o_pulse at n+1; no backpressure, extra edges saturate the pending flag.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int COIN_FRAMES = 3
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_req,
    input  logic i_tick,
    output logic o_pulse
);
    localparam logic [7:0] LOAD = 8'(COIN_FRAMES);

    coin_state_t r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_req, r_req_d;
    logic        w_edge;

    assign w_edge  = r_req & ~r_req_d;
    assign o_pulse = (r_state == COIN_PULSE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= COIN_IDLE;
            r_cnt   <= 8'd0;
            r_pend  <= 1'b0;
            r_req   <= 1'b0;
            r_req_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_req   <= i_req;
            r_req_d <= r_req;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        case (r_state)
            COIN_IDLE: begin
                if (w_edge) begin
                    w_state_nxt = COIN_PULSE;
                    w_cnt_nxt   = LOAD;
                end
            end
            COIN_PULSE: begin
                w_pend_nxt = r_pend | w_edge;
                if (i_tick) begin
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = COIN_GAP;
                        w_cnt_nxt   = LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end
            COIN_GAP: begin
                w_pend_nxt = r_pend | w_edge;
                if (i_tick) begin
                    if (r_cnt == 8'd1) begin
                        // An edge arriving on the final gap tick counts as pending, not lost.
                        if (r_pend | w_edge) begin
                            w_state_nxt = COIN_PULSE;
                            w_cnt_nxt   = LOAD;
                            w_pend_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = COIN_IDLE;
                            w_cnt_nxt   = 8'd0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end
            default: w_state_nxt = COIN_IDLE;
        endcase
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and HPS joysticks into per-player buttons, start lines and shaped coin pulses (joy 1 cycle, key 2 cycles).
// No backpressure; define INPUT_AUTOCOIN_EN to make each start rising edge also raise that player's coin request.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int COIN_FRAMES = 3
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [10:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    input  logic                      separate,
    input  logic                      frame_tick,
    output logic [16*NUM_PLAYERS-1:0] players,
    output logic [NUM_PLAYERS-1:0]    start,
    output logic [NUM_PLAYERS-1:0]    coin
);
    logic                      r_tog_prev;
    logic [7:0]                r_kb_vec;
    logic [3:0]                r_start_key;  // {F2, 2, F1, 1}
    logic [1:0]                r_coin_key;   // {6, 5}
    logic [16*NUM_PLAYERS-1:0] r_players;
    logic [NUM_PLAYERS-1:0]    r_start;
    logic [NUM_PLAYERS-1:0]    r_coin;

    logic                      w_evt, w_press, w_plain;
    logic [7:0]                w_code;
    logic [3:0]                w_start_key_all, w_coin_key_all;
    logic [15:0]               w_kb16, w_joy_or, w_base;
    logic [16*NUM_PLAYERS-1:0] w_players;
    logic [NUM_PLAYERS-1:0]    w_start_req, w_coin_req, w_pulse;

    assign w_evt   = ps2_key[10] ^ r_tog_prev;
    assign w_press = ps2_key[9];
    assign w_plain = ~ps2_key[8];
    assign w_code  = ps2_key[7:0];

    // Toggle history follows the input even in reset, so releasing reset never looks like an event.
    always_ff @(posedge clk_sys) begin
        r_tog_prev <= ps2_key[10];
        if (reset) begin
            r_kb_vec    <= 8'h00;
            r_start_key <= 4'h0;
            r_coin_key  <= 2'b00;
        end else if (w_evt) begin
            case (w_code)
                SC_UP:    r_kb_vec[BTN_UP]    <= w_press;
                SC_DOWN:  r_kb_vec[BTN_DOWN]  <= w_press;
                SC_LEFT:  r_kb_vec[BTN_LEFT]  <= w_press;
                SC_RIGHT: r_kb_vec[BTN_RIGHT] <= w_press;
                SC_W:     if (w_plain) r_kb_vec[BTN_D] <= w_press;
                SC_A:     if (w_plain) r_kb_vec[BTN_B] <= w_press;
                SC_S:     if (w_plain) r_kb_vec[BTN_C] <= w_press;
                SC_D:     if (w_plain) r_kb_vec[BTN_A] <= w_press;
                SC_1:     if (w_plain) r_start_key[0]  <= w_press;
                SC_F1:    if (w_plain) r_start_key[1]  <= w_press;
                SC_2:     if (w_plain) r_start_key[2]  <= w_press;
                SC_F2:    if (w_plain) r_start_key[3]  <= w_press;
                SC_5:     if (w_plain) r_coin_key[0]   <= w_press;
                SC_6:     if (w_plain) r_coin_key[1]   <= w_press;
                default: ;
            endcase
        end
    end

    // Padding to four players drops key requests aimed at absent players.
    assign w_start_key_all = {2'b00, r_start_key[3] | r_start_key[2], r_start_key[1] | r_start_key[0]};
    assign w_coin_key_all  = {2'b00, r_coin_key};
    assign w_kb16          = {8'h00, r_kb_vec};

    always_comb begin
        w_joy_or = 16'h0000;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_joy_or = w_joy_or | joy[16*i +: 16];
        end
    end

    always_comb begin
        w_players   = '0;
        w_start_req = '0;
        w_coin_req  = '0;
        w_base      = 16'h0000;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_start_req[i] = joy[16*i + BTN_START] | w_start_key_all[i];
            w_coin_req[i]  = joy[16*i + BTN_COIN]  | w_coin_key_all[i];
`ifdef INPUT_AUTOCOIN_EN
            w_coin_req[i]  = w_coin_req[i] | (w_start_req[i] & ~r_start[i]);
`endif
            if (separate) begin
                w_base = joy[16*i +: 16] | ((i == 0) ? w_kb16 : 16'h0000);
            end else begin
                w_base = w_joy_or | w_kb16;
            end
            w_base[BTN_START]     = w_start_req[i];
            w_base[BTN_COIN]      = w_pulse[i];
            w_players[16*i +: 16] = w_base;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_coin
        coin_pulser #(
            .COIN_FRAMES(COIN_FRAMES)
        ) u_coin_pulser (
            .clk_sys (clk_sys),
            .reset   (reset),
            .i_req   (w_coin_req[g]),
            .i_tick  (frame_tick),
            .o_pulse (w_pulse[g])
        );
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_players <= '0;
            r_start   <= '0;
            r_coin    <= '0;
        end else begin
            r_players <= w_players;
            r_start   <= w_start_req;
            r_coin    <= w_pulse;
        end
    end

    assign players = r_players;
    assign start   = r_start;
    assign coin    = r_coin;

endmodule
